// File: rtl/forward_stall_ctrl_if.sv
// Operand-forwarding and stall-control bundle between the ID-stage hazard detectors,
// the regfile and datapath sources, and forward_stall_ctrl.
interface forward_stall_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [3:0]      hazard_ex;
  logic            stall_ex;
  logic [3:0]      hazard_mem;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] ex_result;
  logic [XLEN-1:0] mem_result;
  logic            mem_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            pc_en;
  logic            ifid_en;
  logic            idex_bubble;
  logic            fwd_err;

  // Driver side: detectors, regfile and datapath.
  modport master (
    output hazard_ex, stall_ex, hazard_mem, rs1_data, rs2_data,
           ex_result, mem_result, mem_ready,
    input  op1, op2, pc_en, ifid_en, idex_bubble, fwd_err
  );

  // Controller side.
  modport slave (
    input  hazard_ex, stall_ex, hazard_mem, rs1_data, rs2_data,
           ex_result, mem_result, mem_ready,
    output op1, op2, pc_en, ifid_en, idex_bubble, fwd_err
  );
endinterface

// File: rtl/forward_stall_ctrl.sv
// ID-stage operand forwarding, load-use interlock with memory wait, and retiring-operand hold slot.
// Optional FWD_PERF_CNT_EN adds a saturating stall-cycle counter on the stall_cnt port.
module forward_stall_ctrl #(
  parameter int unsigned XLEN  = 32
`ifdef FWD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  forward_stall_ctrl_if.slave bus
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_EX_RS1  = 3'd1;
  localparam logic [2:0] CODE_EX_RS2  = 3'd2;
  localparam logic [2:0] CODE_MEM_RS1 = 3'd3;
  localparam logic [2:0] CODE_MEM_RS2 = 3'd4;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_LU_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            hold_vld_q, hold_vld_d;
  logic            hold_sel_q, hold_sel_d;   // 0: rs1, 1: rs2
  logic [XLEN-1:0] hold_data_q, hold_data_d;
  logic            fwd_err_q, fwd_err_d;

  logic            ex_vld, mem_vld;
  logic [2:0]      ex_code, mem_code;
  logic            ex_fwd_rs1, ex_fwd_rs2, mem_fwd_rs1, mem_fwd_rs2;
  logic            hold_rs1, hold_rs2;
  logic            ex_bad, mem_bad;
  logic            stall;

  assign ex_vld   = bus.hazard_ex[3];
  assign ex_code  = bus.hazard_ex[2:0];
  assign mem_vld  = bus.hazard_mem[3];
  assign mem_code = bus.hazard_mem[2:0];

  // Hazard decode; a load-use flag turns an EX hit into an interlock rather than a forward.
  always_comb begin
    ex_fwd_rs1  = ex_vld && (ex_code == CODE_EX_RS1) && !bus.stall_ex;
    ex_fwd_rs2  = ex_vld && (ex_code == CODE_EX_RS2) && !bus.stall_ex;
    mem_fwd_rs1 = mem_vld && (mem_code == CODE_MEM_RS1);
    mem_fwd_rs2 = mem_vld && (mem_code == CODE_MEM_RS2);
    hold_rs1    = (state_q == ST_LU_WAIT) && hold_vld_q && !hold_sel_q;
    hold_rs2    = (state_q == ST_LU_WAIT) && hold_vld_q &&  hold_sel_q;
    ex_bad      = ex_vld && ((ex_code == CODE_NONE) || (ex_code > CODE_MEM_RS2) ||
                  (((ex_code == CODE_MEM_RS1) || (ex_code == CODE_MEM_RS2)) && !bus.stall_ex));
    mem_bad     = mem_vld && ((mem_code == CODE_NONE) || (mem_code > CODE_MEM_RS2));
  end

  // Operand muxes: EX beats MEM beats hold slot beats regfile; forced to zero under reset.
  always_comb begin
    bus.op1 = '0;
    bus.op2 = '0;
    if (rst_n) begin
      if (ex_fwd_rs1)       bus.op1 = bus.ex_result;
      else if (mem_fwd_rs1) bus.op1 = bus.mem_result;
      else if (hold_rs1)    bus.op1 = hold_data_q;
      else                  bus.op1 = bus.rs1_data;

      if (ex_fwd_rs2)       bus.op2 = bus.ex_result;
      else if (mem_fwd_rs2) bus.op2 = bus.mem_result;
      else if (hold_rs2)    bus.op2 = hold_data_q;
      else                  bus.op2 = bus.rs2_data;
    end
  end

  // Interlock next-state and pipeline enables.
  always_comb begin
    state_d     = state_q;
    hold_vld_d  = hold_vld_q;
    hold_sel_d  = hold_sel_q;
    hold_data_d = hold_data_q;
    stall       = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.stall_ex) begin
          stall       = 1'b1;
          state_d     = ST_LU_WAIT;
          hold_vld_d  = mem_fwd_rs1 || mem_fwd_rs2;
          hold_sel_d  = mem_fwd_rs2;
          hold_data_d = bus.mem_result;
        end
      end
      ST_LU_WAIT: begin
        if (bus.mem_ready) begin
          state_d    = ST_RUN;
          hold_vld_d = 1'b0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (!rst_n) stall = 1'b1;

    bus.pc_en       = !stall;
    bus.ifid_en     = !stall;
    bus.idex_bubble = stall;
  end

  assign fwd_err_d   = fwd_err_q || ex_bad || mem_bad;
  assign bus.fwd_err = fwd_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      hold_vld_q  <= 1'b0;
      hold_sel_q  <= 1'b0;
      hold_data_q <= '0;
      fwd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_vld_q  <= hold_vld_d;
      hold_sel_q  <= hold_sel_d;
      hold_data_q <= hold_data_d;
      fwd_err_q   <= fwd_err_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of bubble cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
